// File: rtl/shift_arbiter_if.sv
// Request/response bundle for shift_arbiter: two requester ports feeding one
// shared shift engine, plus the single response port.
interface shift_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_data0;
    logic [15:0] req_data1;
    logic [3:0]  req_amt0;
    logic [3:0]  req_amt1;
    logic [1:0]  req_op0;
    logic [1:0]  req_op1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic        busy;

    // Requesters and the response consumer.
    modport master (
        output req_valid, req_data0, req_data1, req_amt0, req_amt1,
               req_op0, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_data0, req_data1, req_amt0, req_amt1,
               req_op0, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter in front of one shared 16-bit logical
// right barrel shifter. Left shifts reuse the shifter through bit reversal;
// rotates take two passes (k and 16-k in opposite directions), OR-combined.

// 16-bit logical right shifter with a one-hot shift amount.
module barrel_shift16 (
    input  logic [15:0] d,
    input  logic [15:0] n,
    output logic [15:0] w
);
    // The single set bit of n selects which right-shifted copy of d reaches w.
    always_comb begin
        w = '0;
        for (int i = 0; i < 16; i++) begin
            if (n[i]) w = w | (d >> i);
        end
    end
endmodule

module shift_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    shift_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        RESP  = 2'd3
    } state_t;

    // op[0] = 1 means the first pass goes left; op[1] = 1 means rotate (two passes).
    state_t      state;
    state_t      state_nx;
    logic [15:0] opnd;
    logic [3:0]  amt;
    logic [1:0]  op;
    logic        id;
    logic        last;
    logic [15:0] acc;
    logic [15:0] n_sel;

    logic [1:0]  grant;
    logic        grant_id;
    logic        accept;
    logic [15:0] sel_data;
    logic [3:0]  sel_amt;
    logic [1:0]  sel_op;
    logic        go_left;
    logic [15:0] sh_in;
    logic [15:0] sh_out;
    logic [15:0] pass_res;

    function automatic logic [15:0] rev16(input logic [15:0] x);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = x[15-i];
        return r;
    endfunction

    function automatic logic [15:0] onehot16(input logic [3:0] k);
        return 16'h0001 << k;
    endfunction

    // Round-robin grant, offered only in IDLE and never while reset is held.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant = 2'b00;
        if (state == IDLE && rst_n) begin
            unique case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign grant_id      = grant[1];
    assign accept        = |grant;   // grant is only raised on a valid bit, so grant == transfer
    assign bus.req_ready = grant;

    assign sel_data = grant_id ? bus.req_data1 : bus.req_data0;
    assign sel_amt  = grant_id ? bus.req_amt1  : bus.req_amt0;
    assign sel_op   = grant_id ? bus.req_op1   : bus.req_op0;

    // Direction of the current pass: the second pass of a rotate runs opposite to the first.
    assign go_left  = (state == PASS2) ? ~op[0] : op[0];
    assign sh_in    = go_left ? rev16(opnd) : opnd;
    assign pass_res = go_left ? rev16(sh_out) : sh_out;

    barrel_shift16 u_shift (
        .d (sh_in),
        .n (n_sel),
        .w (sh_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = PASS1;
            PASS1:   state_nx = op[1] ? PASS2 : RESP;
            PASS2:   state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Transaction capture, pass amount register and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd  <= '0;
            amt   <= '0;
            op    <= '0;
            id    <= 1'b0;
            last  <= 1'b1;
            acc   <= '0;
            n_sel <= 16'h0001;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        opnd  <= sel_data;
                        amt   <= sel_amt;
                        op    <= sel_op;
                        id    <= grant_id;
                        last  <= grant_id;
                        n_sel <= onehot16(sel_amt);
                    end
                end
                PASS1: begin
                    acc <= pass_res;
                    // Second pass amount is (16 - k) mod 16; k = 0 gives 0 and leaves the word intact.
                    if (op[1]) n_sel <= onehot16(4'd0 - amt);
                end
                PASS2:   acc <= acc | pass_res;
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = acc;
    assign bus.rsp_id    = id;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: stimulus pushes hand-computed expected
// responses; a negedge monitor pops and compares whenever a response transfers.
module tb_shift_arbiter;
    localparam logic [1:0] SRL = 2'b00;
    localparam logic [1:0] SLL = 2'b01;
    localparam logic [1:0] ROR = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_arbiter_if ifc ();

    shift_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    typedef struct {
        int          id;
        logic [15:0] data;
        int          lat;
        int          acc_edge;
    } exp_t;

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [15:0] d;
        logic [3:0]  k;
        logic [15:0] exp;
    } vec_t;

    exp_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    bit   in_resp = 1'b0;
    logic [15:0] held_data;
    logic        held_id;

    // Directed vectors, expected results worked out by hand.
    vec_t vecs [0:11] = '{
        '{0, SRL, 16'h8001, 4'd4,  16'h0800},
        '{1, SLL, 16'h8001, 4'd4,  16'h0010},
        '{1, ROR, 16'h8001, 4'd4,  16'h1800},
        '{1, ROL, 16'h8001, 4'd4,  16'h0018},
        '{0, ROR, 16'hA5C3, 4'd0,  16'hA5C3},
        '{1, ROL, 16'hA5C3, 4'd0,  16'hA5C3},
        '{0, SRL, 16'hFFFF, 4'd15, 16'h0001},
        '{0, SLL, 16'hA5C3, 4'd0,  16'hA5C3},
        '{1, SRL, 16'hA5C3, 4'd0,  16'hA5C3},
        '{0, ROL, 16'h1234, 4'd8,  16'h3412},
        '{1, ROR, 16'h0001, 4'd1,  16'h8000},
        '{0, SLL, 16'hFFFF, 4'd15, 16'h8000}
    };

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [15:0] d, input logic [3:0] k);
        if (id == 0) begin
            ifc.req_op0 = op; ifc.req_data0 = d; ifc.req_amt0 = k;
        end else begin
            ifc.req_op1 = op; ifc.req_data1 = d; ifc.req_amt1 = k;
        end
    endtask

    task automatic push_exp(input int id, input logic [15:0] data, input logic [1:0] op, input int edge_no);
        exp_t e;
        e.id       = id;
        e.data     = data;
        e.lat      = op[1] ? 3 : 2;
        e.acc_edge = edge_no;
        sb.push_back(e);
    endtask

    // Drive one request until accepted, then scramble its inputs to show they are not re-read.
    task automatic issue(input int id, input logic [1:0] op, input logic [15:0] d,
                         input logic [3:0] k, input logic [15:0] exp, input bit expect_rsp);
        int  waited = 0;
        bit  done   = 1'b0;
        @(posedge clk); #1;
        set_req(id, op, d, k);
        ifc.req_valid[id] = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (ifc.req_ready[id]) begin
                check("ready_exclusive", {31'd0, ifc.req_ready[1-id]}, 32'd0);
                if (expect_rsp) push_exp(id, exp, op, cyc + 1);
                done = 1'b1;
            end else if (++waited > 50) begin
                fail("accept_timeout");
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
        ifc.req_valid[id] = 1'b0;
        set_req(id, ~op, ~d, ~k);
    endtask

    task automatic drain();
        int w = 0;
        while ((sb.size() != 0 || in_resp) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            fail("drain_timeout");
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Response monitor: latency on the rising response, stability while stalled, compare on transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_resp = 1'b0;
        end else begin
            if (in_resp) begin
                check("rsp_valid_hold", {31'd0, ifc.rsp_valid}, 32'd1);
                check("rsp_data_stable", {16'd0, ifc.rsp_data}, {16'd0, held_data});
                check("rsp_id_stable", {31'd0, ifc.rsp_id}, {31'd0, held_id});
                check("ready_in_resp", {30'd0, ifc.req_ready}, 32'd0);
                check("busy_in_resp", {31'd0, ifc.busy}, 32'd1);
            end else if (ifc.rsp_valid) begin
                if (sb.size() == 0) begin
                    fail("unexpected_response");
                end else begin
                    in_resp   = 1'b1;
                    held_data = ifc.rsp_data;
                    held_id   = ifc.rsp_id;
                    check("latency", (cyc + 1) - sb[0].acc_edge, sb[0].lat);
                end
            end
            if (in_resp && ifc.rsp_ready) begin
                check("rsp_data", {16'd0, ifc.rsp_data}, {16'd0, sb[0].data});
                check("rsp_id", {31'd0, ifc.rsp_id}, sb[0].id);
                void'(sb.pop_front());
                in_resp = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int grants;
        int waited;
        int w;

        ifc.req_valid = 2'b00;
        ifc.rsp_ready = 1'b1;
        set_req(0, SRL, 16'h0000, 4'd0);
        set_req(1, SRL, 16'h0000, 4'd0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("reset_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
        check("reset_rsp_data", {16'd0, ifc.rsp_data}, 32'd0);
        check("reset_rsp_id", {31'd0, ifc.rsp_id}, 32'd0);
        check("reset_busy", {31'd0, ifc.busy}, 32'd0);

        // Both requesters valid from reset release: grants alternate 0,1,0,1.
        set_req(0, SRL, 16'h00F0, 4'd4);
        set_req(1, SLL, 16'h00F0, 4'd4);
        ifc.req_valid = 2'b11;
        #1;
        check("reset_req_ready", {30'd0, ifc.req_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        grants = 0;
        waited = 0;
        while (grants < 4 && waited < 100) begin
            @(negedge clk);
            waited++;
            if (ifc.req_ready != 2'b00) begin
                check("rr_grant", {30'd0, ifc.req_ready}, (grants % 2 == 0) ? 32'd1 : 32'd2);
                if (grants % 2 == 0) push_exp(0, 16'h000F, SRL, cyc + 1);
                else                 push_exp(1, 16'h0F00, SLL, cyc + 1);
                grants++;
            end
        end
        if (grants < 4) fail("rr_timeout");
        @(posedge clk); #1;
        ifc.req_valid = 2'b00;
        drain();

        // Directed vectors through each requester.
        foreach (vecs[i]) begin
            issue(vecs[i].id, vecs[i].op, vecs[i].d, vecs[i].k, vecs[i].exp, 1'b1);
        end
        drain();

        // Consumer stalls five cycles in RESP.
        ifc.rsp_ready = 1'b0;
        issue(0, SLL, 16'h0F0F, 4'd4, 16'hF0F0, 1'b1);
        w = 0;
        while (!in_resp && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_resp) fail("stall_no_response");
        repeat (5) @(posedge clk);
        #1;
        ifc.rsp_ready = 1'b1;
        drain();

        // Reset pulsed during PASS2 of a rotate: the transaction is dropped.
        issue(1, ROL, 16'h00FF, 4'd4, 16'h0000, 1'b0);
        @(posedge clk); #1;
        check("busy_in_pass2", {31'd0, ifc.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
        check("midrst_rsp_data", {16'd0, ifc.rsp_data}, 32'd0);
        check("midrst_rsp_id", {31'd0, ifc.rsp_id}, 32'd0);
        check("midrst_busy", {31'd0, ifc.busy}, 32'd0);
        check("midrst_req_ready", {30'd0, ifc.req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(0, ROR, 16'h00FF, 4'd4, 16'hF00F, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
